sm_frame_loader: RTL and testbench

- Host-side writer for the system memory: accepts 24-bit pixel words over a valid/ready handshake and writes one full frame into system memory at sequential addresses.
- When the frame is complete, asserts CSDisplay to hand the frame to the display controller, then holds off the host until the controller reports FrameDone.
- Sits between the host interface and the system memory write port, feeding WESM, AddrSM and WData.

---
 rtl/sm_frame_loader.sv | 118 +++++++++++
 tb/tb_sm_frame_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_frame_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sm_frame_loader: writes one host frame into system memory, then hands it |
// | to the display controller and holds the host off until FrameDone.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sm_frame_loader #(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 24,
   parameter int FRAME_WORDS = 100
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              HostValid,
   input  logic [DATA_W-1:0] HostData,
   input  logic              HostLast,
   output logic              HostReady,
   input  logic              RESM,
   input  logic              FrameDone,
   input  logic              ClearError,
   output logic              WESM,
   output logic [ADDR_W-1:0] AddrSM,
   output logic [DATA_W-1:0] WData,
   output logic              CSDisplay,
   output logic              LoadError,
   output logic [ADDR_W-1:0] WordCount
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      ARM     = 2'd2,
      DISPLAY = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_WORDS - 1);

   state_t            state;
   state_t            state_nx;
   logic              accept;
   logic              last_word;
   logic              frame_ok;
   logic              frame_bad;
   logic [ADDR_W-1:0] count_nx;
   logic              cs_nx;
   logic              err_nx;

   assign HostReady = !Reset && ((state == IDLE) || (state == LOAD)) && !RESM;
   assign accept    = HostValid & HostReady;
   assign last_word = (WordCount == LAST_IDX);
   assign frame_ok  = accept & last_word & HostLast;
   // A frame is malformed when HostLast disagrees with the word position.
   assign frame_bad = accept & (last_word ^ HostLast);

   always_comb begin
      state_nx = state;
      count_nx = WordCount;
      cs_nx    = CSDisplay;
      err_nx   = ClearError ? 1'b0 : LoadError;
      case (state)
         IDLE, LOAD: begin
            if (frame_ok) begin
               state_nx = ARM;
               count_nx = '0;
            end else if (frame_bad) begin
               state_nx = IDLE;
               count_nx = '0;
               err_nx   = 1'b1;
            end else if (accept) begin
               state_nx = LOAD;
               count_nx = WordCount + ADDR_W'(1);
            end
         end
         ARM: begin
            state_nx = DISPLAY;
            count_nx = '0;
            cs_nx    = 1'b1;
         end
         DISPLAY: begin
            if (FrameDone) begin
               state_nx = IDLE;
               cs_nx    = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         WESM      <= 1'b0;
         AddrSM    <= '0;
         WData     <= '0;
         CSDisplay <= 1'b0;
         LoadError <= 1'b0;
         WordCount <= '0;
      end else begin
         WESM      <= accept;
         CSDisplay <= cs_nx;
         LoadError <= err_nx;
         WordCount <= count_nx;
         if (accept) begin
            AddrSM <= WordCount;
            WData  <= HostData;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sm_frame_loader.sv
`default_nettype none
// Directed bench for sm_frame_loader: frame-level reference model compared
// every falling edge, plus literal spot checks at key moments.
module tb_sm_frame_loader;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 24;
   localparam int FW     = 100;

   logic              Clock = 1'b0;
   logic              Reset;
   logic              HostValid;
   logic [DATA_W-1:0] HostData;
   logic              HostLast;
   logic              HostReady;
   logic              RESM;
   logic              FrameDone;
   logic              ClearError;
   logic              WESM;
   logic [ADDR_W-1:0] AddrSM;
   logic [DATA_W-1:0] WData;
   logic              CSDisplay;
   logic              LoadError;
   logic [ADDR_W-1:0] WordCount;

   int checks   = 0;
   int failures = 0;

   sm_frame_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_WORDS(FW)) dut (
      .Clock(Clock), .Reset(Reset), .HostValid(HostValid), .HostData(HostData),
      .HostLast(HostLast), .HostReady(HostReady), .RESM(RESM), .FrameDone(FrameDone),
      .ClearError(ClearError), .WESM(WESM), .AddrSM(AddrSM), .WData(WData),
      .CSDisplay(CSDisplay), .LoadError(LoadError), .WordCount(WordCount)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: words received so far, whether a finished frame is
   // waiting to be shown (1) or being shown (2), and the expected outputs.
   int          m_count;
   int          m_hold;
   logic        m_cs, m_err, m_we;
   int          m_addr;
   logic [23:0] m_data;

   always @(posedge Clock or posedge Reset) begin
      int   cnt, hold, addr;
      logic cs, err, we, bad, took;
      logic [23:0] dat;
      if (Reset) begin
         m_count <= 0; m_hold <= 0; m_cs <= 1'b0; m_err <= 1'b0;
         m_we <= 1'b0; m_addr <= 0; m_data <= '0;
      end else begin
         cnt = m_count; hold = m_hold; cs = m_cs; err = m_err;
         addr = m_addr; dat = m_data; bad = 1'b0;
         took = HostValid && !RESM && (m_hold == 0);
         we = took;
         if (took) begin
            addr = m_count;
            dat  = HostData;
            if (m_count == FW - 1 && HostLast) begin
               hold = 1; cnt = 0;
            end else if (m_count == FW - 1 || HostLast) begin
               bad = 1'b1; cnt = 0;
            end else begin
               cnt = m_count + 1;
            end
         end
         if (m_hold == 1) begin
            hold = 2; cs = 1'b1;
         end else if (m_hold == 2 && FrameDone) begin
            hold = 0; cs = 1'b0;
         end
         if (bad) err = 1'b1;
         else if (ClearError) err = 1'b0;
         m_count <= cnt; m_hold <= hold; m_cs <= cs; m_err <= err;
         m_we <= we; m_addr <= addr; m_data <= dat;
      end
   end

   always @(negedge Clock) begin
      chk("HostReady", HostReady, (!Reset && m_hold == 0 && !RESM));
      chk("WESM", WESM, m_we);
      chk("AddrSM", AddrSM, m_addr);
      chk("WData", WData, m_data);
      chk("CSDisplay", CSDisplay, m_cs);
      chk("LoadError", LoadError, m_err);
      chk("WordCount", WordCount, m_count);
   end

   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic send_word(input logic [23:0] d, input logic last);
      int   n;
      logic rdy;
      HostValid = 1'b1; HostData = d; HostLast = last; n = 0;
      do begin
         @(negedge Clock);
         rdy = HostReady;
         @(posedge Clock);
         n++;
      end while (!rdy && n < 50);
      #1;
      HostValid = 1'b0; HostLast = 1'b0;
      if (!rdy) begin
         checks++; failures++;
         $display("FAIL accept_timeout: word %06h never accepted within %0d cycles", d, n);
      end
   endtask

   function automatic logic [23:0] pix(input int i);
      return 24'(i * 32'h010101);
   endfunction

   task automatic pulse_done();
      FrameDone = 1'b1; cyc(); FrameDone = 1'b0;
   endtask

   task automatic pulse_clear();
      ClearError = 1'b1; cyc(); ClearError = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; HostValid = 1'b0; HostData = '0; HostLast = 1'b0;
      RESM = 1'b0; FrameDone = 1'b0; ClearError = 1'b0;
      repeat (2) cyc();
      chk("rst_HostReady", HostReady, 0);
      chk("rst_WESM", WESM, 0);
      chk("rst_CSDisplay", CSDisplay, 0);
      chk("rst_WordCount", WordCount, 0);
      Reset = 1'b0;
      #1;
      chk("idle_HostReady", HostReady, 1);
      cyc();

      // Nominal frame; a FrameDone during loading must be ignored.
      for (int i = 0; i < FW; i++) begin
         if (i == 30) FrameDone = 1'b1;
         send_word(pix(i), i == FW - 1);
         FrameDone = 1'b0;
         if (i == 30) chk("load_done_ignored_count", WordCount, 31);
      end
      chk("last_WESM", WESM, 1);
      chk("last_AddrSM", AddrSM, 99);
      chk("last_WData", WData, 24'h636363);
      chk("arm_CSDisplay", CSDisplay, 0);
      cyc();
      chk("cs_rise", CSDisplay, 1);
      chk("display_HostReady", HostReady, 0);
      repeat (3) cyc();
      pulse_done();
      chk("handoff_CSDisplay", CSDisplay, 0);
      chk("handoff_HostReady", HostReady, 1);
      cyc();

      // Early HostLast on word 41.
      for (int i = 0; i < 42; i++) send_word(pix(i), i == 41);
      chk("early_AddrSM", AddrSM, 41);
      chk("early_WData", WData, 24'h292929);
      chk("early_LoadError", LoadError, 1);
      chk("early_WordCount", WordCount, 0);
      send_word(pix(0), 1'b0);
      chk("restart_AddrSM", AddrSM, 0);
      pulse_clear();
      chk("clear_LoadError", LoadError, 0);

      // Missing HostLast, with ClearError coinciding with the error (set wins).
      for (int i = 1; i < FW; i++) begin
         if (i == FW - 1) ClearError = 1'b1;
         send_word(pix(i), 1'b0);
         ClearError = 1'b0;
      end
      chk("missing_LoadError", LoadError, 1);
      chk("missing_CSDisplay", CSDisplay, 0);
      pulse_clear();
      chk("missing_cleared", LoadError, 0);

      // RESM stall during word 20.
      for (int i = 0; i < 20; i++) send_word(pix(i), 1'b0);
      RESM = 1'b1; HostValid = 1'b1; HostData = pix(20);
      repeat (5) cyc();
      chk("stall_WordCount", WordCount, 20);
      chk("stall_WESM", WESM, 0);
      chk("stall_HostReady", HostReady, 0);
      RESM = 1'b0;
      send_word(pix(20), 1'b0);
      chk("stall_AddrSM", AddrSM, 20);
      chk("stall_WData", WData, 24'h141414);
      for (int i = 21; i < FW; i++) send_word(pix(i), i == FW - 1);
      repeat (2) cyc();
      chk("stall_frame_cs", CSDisplay, 1);
      pulse_done();

      // Asynchronous reset mid-load.
      for (int i = 0; i < 50; i++) send_word(pix(i), 1'b0);
      #2 Reset = 1'b1;
      #1;
      chk("amid_WESM", WESM, 0);
      chk("amid_WordCount", WordCount, 0);
      chk("amid_CSDisplay", CSDisplay, 0);
      chk("amid_HostReady", HostReady, 0);
      cyc();
      Reset = 1'b0;
      cyc();
      send_word(pix(7), 1'b0);
      chk("post_reset_AddrSM", AddrSM, 0);
      chk("post_reset_WESM", WESM, 1);
      repeat (3) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
